// File: rtl/unary_job_sched.sv
// unary_job_sched: round-robin two-requester sequencer for the unary datapath.
// Ports: Req/A/B per requester in, Gnt pulses out, Dp_* to the datapath,
// Res0/Res1 captured results, Done/Done_Id completion, Busy while not idle.
module unary_job_sched #(
    parameter int WIDTH       = 8,
    parameter int LOAD_CYCLES = 2,
    parameter int RUN_CYCLES  = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Req0,
    input  logic             Req1,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] B0,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B1,
    output logic             Gnt0,
    output logic             Gnt1,
    output logic [WIDTH-1:0] Dp_Init0,
    output logic [WIDTH-1:0] Dp_Init1,
    output logic             Dp_Load,
    input  logic [WIDTH-1:0] Dp_Unary0,
    input  logic [WIDTH-1:0] Dp_Unary1,
    output logic [WIDTH-1:0] Res0,
    output logic [WIDTH-1:0] Res1,
    output logic             Done,
    output logic             Done_Id,
    output logic             Busy
);

    localparam int MAXC = (LOAD_CYCLES > RUN_CYCLES) ? LOAD_CYCLES : RUN_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;

    localparam logic [CW-1:0] LOAD_LAST = CW'(LOAD_CYCLES - 1);
    localparam logic [CW-1:0] RUN_LAST  = CW'(RUN_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_id_q, last_id_d;
    logic             cur_id_q, cur_id_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic [WIDTH-1:0] init0_q, init0_d;
    logic [WIDTH-1:0] init1_q, init1_d;
    logic             load_q, load_d;
    logic [WIDTH-1:0] res0_q, res0_d;
    logic [WIDTH-1:0] res1_q, res1_d;
    logic             done_q, done_d;
    logic             done_id_q, done_id_d;
    logic             busy_q, busy_d;
    logic             win;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_id_d = last_id_q;
        cur_id_d  = cur_id_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        init0_d   = init0_q;
        init1_d   = init1_q;
        load_d    = load_q;
        res0_d    = res0_q;
        res1_d    = res1_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        win       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (Req0 || Req1) begin
                    // Contest goes to the side that did not win last;
                    // a lone request wins regardless of the pointer.
                    win       = (Req0 && Req1) ? ~last_id_q : Req1;
                    gnt0_d    = ~win;
                    gnt1_d    = win;
                    init0_d   = win ? A1 : A0;
                    init1_d   = win ? B1 : B0;
                    load_d    = 1'b1;
                    cnt_d     = '0;
                    cur_id_d  = win;
                    last_id_d = win;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (cnt_q == LOAD_LAST) begin
                    load_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RUN: begin
                if (cnt_q == RUN_LAST) begin
                    res0_d    = Dp_Unary0;
                    res1_d    = Dp_Unary1;
                    done_d    = 1'b1;
                    done_id_d = cur_id_q;
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                load_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            last_id_q <= 1'b1;
            cur_id_q  <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            init0_q   <= '0;
            init1_q   <= '0;
            load_q    <= 1'b0;
            res0_q    <= '0;
            res1_q    <= '0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_id_q <= last_id_d;
            cur_id_q  <= cur_id_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            init0_q   <= init0_d;
            init1_q   <= init1_d;
            load_q    <= load_d;
            res0_q    <= res0_d;
            res1_q    <= res1_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            busy_q    <= busy_d;
        end
    end

    assign Gnt0     = gnt0_q;
    assign Gnt1     = gnt1_q;
    assign Dp_Init0 = init0_q;
    assign Dp_Init1 = init1_q;
    assign Dp_Load  = load_q;
    assign Res0     = res0_q;
    assign Res1     = res1_q;
    assign Done     = done_q;
    assign Done_Id  = done_id_q;
    assign Busy     = busy_q;

endmodule

// File: tb/tb_unary_job_sched.sv
// tb_unary_job_sched: scenario tasks with a job scoreboard for unary_job_sched.
// Expected completions are queued at grant and compared when Done fires.
module tb_unary_job_sched;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Req0 = 1'b0, Req1 = 1'b0;
    logic [7:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
    logic       Gnt0, Gnt1, Dp_Load, Done, Done_Id, Busy;
    logic [7:0] Dp_Init0, Dp_Init1, Res0, Res1;
    logic [7:0] Dp_Unary0 = '0, Dp_Unary1 = '0;

    typedef struct {
        logic       id;
        logic [7:0] r0;
        logic [7:0] r1;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    unary_job_sched dut (
        .Clk(Clk), .Reset(Reset),
        .Req0(Req0), .Req1(Req1),
        .A0(A0), .B0(B0), .A1(A1), .B1(B1),
        .Gnt0(Gnt0), .Gnt1(Gnt1),
        .Dp_Init0(Dp_Init0), .Dp_Init1(Dp_Init1),
        .Dp_Load(Dp_Load),
        .Dp_Unary0(Dp_Unary0), .Dp_Unary1(Dp_Unary1),
        .Res0(Res0), .Res1(Res1),
        .Done(Done), .Done_Id(Done_Id), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    task automatic do_reset();
        Reset = 1'b0;
        Req0 = 1'b0;
        Req1 = 1'b0;
        sb.delete();
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    // Advances negedges until Done; cyc counts cycles after the call.
    task automatic wait_done(output bit seen, output int cyc);
        seen = 0;
        cyc = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clk);
            if (Done) begin
                seen = 1;
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        #1;
        total_cnt++;
        if ({Gnt0, Gnt1, Dp_Load, Done, Done_Id, Busy} !== 6'b0)
            $display("FAIL rst_ctl: got %b want 000000",
                     {Gnt0, Gnt1, Dp_Load, Done, Done_Id, Busy});
        else pass_cnt++;
        total_cnt++;
        if ({Dp_Init0, Dp_Init1, Res0, Res1} !== 32'h0)
            $display("FAIL rst_data: got %h want 0",
                     {Dp_Init0, Dp_Init1, Res0, Res1});
        else pass_cnt++;
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic test_single();
        int   loads;
        bit   seen;
        int   cyc;
        exp_t e;
        do_reset();
        A0 = 8'd10; B0 = 8'd15; Req0 = 1'b1;
        Dp_Unary0 = 8'h3C; Dp_Unary1 = 8'hA5;
        @(negedge Clk);
        total_cnt++;
        if ({Gnt0, Gnt1, Dp_Load, Busy} !== 4'b1011)
            $display("FAIL single_gnt: got %b want 1011",
                     {Gnt0, Gnt1, Dp_Load, Busy});
        else pass_cnt++;
        total_cnt++;
        if (Dp_Init0 !== 8'd10 || Dp_Init1 !== 8'd15)
            $display("FAIL single_init: got %0d/%0d want 10/15",
                     Dp_Init0, Dp_Init1);
        else pass_cnt++;
        sb.push_back('{1'b0, 8'h3C, 8'hA5});
        Req0 = 1'b0;
        loads = 1;
        seen = 0;
        cyc = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clk);
            if (Done) begin
                seen = 1;
                cyc = k;
                break;
            end
            loads += int'(Dp_Load);
        end
        total_cnt++;
        if (!seen || cyc != 10)
            $display("FAIL single_lat: got %0d want 10", cyc);
        else pass_cnt++;
        total_cnt++;
        if (loads != 2)
            $display("FAIL single_load: got %0d want 2", loads);
        else pass_cnt++;
        total_cnt++;
        if (Busy !== 1'b0)
            $display("FAIL single_busy: got %b want 0", Busy);
        else pass_cnt++;
        total_cnt++;
        if (sb.size() == 0) begin
            $display("FAIL single_sb: got empty want 1 entry");
        end else begin
            e = sb.pop_front();
            if (Done_Id !== e.id || Res0 !== e.r0 || Res1 !== e.r1)
                $display("FAIL single_res: got %b/%h/%h want %b/%h/%h",
                         Done_Id, Res0, Res1, e.id, e.r0, e.r1);
            else pass_cnt++;
        end
        @(negedge Clk);
        total_cnt++;
        if (Done !== 1'b0)
            $display("FAIL single_pulse: got %b want 0", Done);
        else pass_cnt++;
    endtask

    task automatic test_two();
        bit   seen;
        int   cyc;
        exp_t e;
        do_reset();
        A0 = 8'd112; B0 = 8'd150; A1 = 8'd2; B1 = 8'd0;
        Req0 = 1'b1; Req1 = 1'b1;
        Dp_Unary0 = 8'h01; Dp_Unary1 = 8'h02;
        @(negedge Clk);
        total_cnt++;
        if (Gnt0 !== 1'b1 || Gnt1 !== 1'b0 || Dp_Init0 !== 8'd112)
            $display("FAIL two_first: got %b%b/%0d want 10/112",
                     Gnt0, Gnt1, Dp_Init0);
        else pass_cnt++;
        sb.push_back('{1'b0, 8'h01, 8'h02});
        Req0 = 1'b0;
        wait_done(seen, cyc);
        e = sb.pop_front();
        total_cnt++;
        if (!seen || Done_Id !== e.id || Res0 !== e.r0)
            $display("FAIL two_done0: got %b/%h want %b/%h",
                     Done_Id, Res0, e.id, e.r0);
        else pass_cnt++;
        @(negedge Clk);
        Dp_Unary0 = 8'h77; Dp_Unary1 = 8'h88;
        total_cnt++;
        if (Gnt1 !== 1'b1 || Gnt0 !== 1'b0 ||
            Dp_Init0 !== 8'd2 || Dp_Init1 !== 8'd0)
            $display("FAIL two_second: got %b%b/%0d/%0d want 01/2/0",
                     Gnt0, Gnt1, Dp_Init0, Dp_Init1);
        else pass_cnt++;
        sb.push_back('{1'b1, 8'h77, 8'h88});
        Req1 = 1'b0;
        wait_done(seen, cyc);
        e = sb.pop_front();
        total_cnt++;
        if (!seen || Done_Id !== e.id || Res0 !== e.r0 || Res1 !== e.r1)
            $display("FAIL two_done1: got %b/%h/%h want %b/%h/%h",
                     Done_Id, Res0, Res1, e.id, e.r0, e.r1);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int   order[$];
        int   gcyc[$];
        int   ndone;
        int   g0;
        int   g1;
        int   bad;
        logic [7:0] v;
        exp_t e;
        do_reset();
        A0 = 8'd1; B0 = 8'd2; A1 = 8'd3; B1 = 8'd4;
        Req0 = 1'b1; Req1 = 1'b1;
        ndone = 0; g0 = 0; g1 = 0; bad = 0;
        for (int c = 0; c < 80 && ndone < 4; c++) begin
            @(negedge Clk);
            if ((Gnt0 && Gnt1) || (Done && (Gnt0 || Gnt1))) bad++;
            if (Done) begin
                ndone++;
                total_cnt++;
                if (sb.size() == 0) begin
                    $display("FAIL b2b_sb: got empty want entry");
                end else begin
                    e = sb.pop_front();
                    if (Done_Id !== e.id || Res0 !== e.r0 || Res1 !== e.r1)
                        $display("FAIL b2b_res: got %b/%h/%h want %b/%h/%h",
                                 Done_Id, Res0, Res1, e.id, e.r0, e.r1);
                    else pass_cnt++;
                end
            end
            if (Gnt0 || Gnt1) begin
                order.push_back(int'(Gnt1));
                gcyc.push_back(c);
                v = 8'h50 + 8'(order.size());
                Dp_Unary0 = v;
                Dp_Unary1 = ~v;
                sb.push_back('{Gnt1, v, ~v});
                if (Gnt0) g0++;
                if (Gnt1) g1++;
            end
            Req0 = !Gnt0 && (g0 < 2);
            Req1 = !Gnt1 && (g1 < 2);
        end
        total_cnt++;
        if (bad != 0)
            $display("FAIL b2b_excl: got %0d overlaps want 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (order.size() != 4 || order[0] != 0 || order[1] != 1 ||
            order[2] != 0 || order[3] != 1)
            $display("FAIL b2b_order: got %p want 0,1,0,1", order);
        else pass_cnt++;
        total_cnt++;
        if (gcyc.size() != 4 || gcyc[1] - gcyc[0] != 11 ||
            gcyc[2] - gcyc[1] != 11 || gcyc[3] - gcyc[2] != 11)
            $display("FAIL b2b_period: got %p want step 11", gcyc);
        else pass_cnt++;
        total_cnt++;
        if (ndone != 4)
            $display("FAIL b2b_done: got %0d want 4", ndone);
        else pass_cnt++;
    endtask

    task automatic test_late_req();
        bit   seen;
        bit   early;
        int   cyc;
        exp_t e;
        do_reset();
        A0 = 8'd1; B0 = 8'd1; Req0 = 1'b1;
        Dp_Unary0 = 8'h11; Dp_Unary1 = 8'h22;
        @(negedge Clk);
        sb.push_back('{1'b0, 8'h11, 8'h22});
        Req0 = 1'b0;
        seen = 0;
        early = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clk);
            if (Done) begin
                seen = 1;
                break;
            end
            if (Gnt1) early = 1;
            if (k == 3) begin
                Req1 = 1'b1; A1 = 8'd5; B1 = 8'd7;
            end
            if (k == 6) B1 = 8'd9;
        end
        total_cnt++;
        if (!seen || early)
            $display("FAIL late_hold: got done=%b early=%b want 1/0",
                     seen, early);
        else pass_cnt++;
        e = sb.pop_front();
        total_cnt++;
        if (Done_Id !== e.id || Res0 !== e.r0)
            $display("FAIL late_done0: got %b/%h want %b/%h",
                     Done_Id, Res0, e.id, e.r0);
        else pass_cnt++;
        @(negedge Clk);
        total_cnt++;
        if (Gnt1 !== 1'b1 || Dp_Init0 !== 8'd5 || Dp_Init1 !== 8'd9)
            $display("FAIL late_gnt: got %b/%0d/%0d want 1/5/9",
                     Gnt1, Dp_Init0, Dp_Init1);
        else pass_cnt++;
        sb.push_back('{1'b1, 8'h11, 8'h22});
        Req1 = 1'b0;
        A1 = 8'd44; B1 = 8'd33;
        @(negedge Clk);
        total_cnt++;
        if (Dp_Init0 !== 8'd5 || Dp_Init1 !== 8'd9)
            $display("FAIL late_keep: got %0d/%0d want 5/9",
                     Dp_Init0, Dp_Init1);
        else pass_cnt++;
        wait_done(seen, cyc);
        e = sb.pop_front();
        total_cnt++;
        if (!seen || Done_Id !== e.id)
            $display("FAIL late_done1: got %b want %b", Done_Id, e.id);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit   seen;
        int   cyc;
        exp_t e;
        do_reset();
        A0 = 8'd9; B0 = 8'd9; Req0 = 1'b1;
        Dp_Unary0 = 8'hEE; Dp_Unary1 = 8'hDD;
        @(negedge Clk);
        Req0 = 1'b0;
        repeat (6) @(negedge Clk);
        Req1 = 1'b1; A1 = 8'd77; B1 = 8'd88;
        Reset = 1'b0;
        #1;
        total_cnt++;
        if ({Gnt0, Gnt1, Dp_Load, Done, Done_Id, Busy} !== 6'b0 ||
            {Dp_Init0, Dp_Init1, Res0, Res1} !== 32'h0)
            $display("FAIL mid_rst: got %b/%h want 0/0",
                     {Gnt0, Gnt1, Dp_Load, Done, Done_Id, Busy},
                     {Dp_Init0, Dp_Init1, Res0, Res1});
        else pass_cnt++;
        @(negedge Clk);
        total_cnt++;
        if (Done !== 1'b0 || Busy !== 1'b0)
            $display("FAIL mid_nodone: got %b%b want 00", Done, Busy);
        else pass_cnt++;
        Reset = 1'b1;
        @(negedge Clk);
        total_cnt++;
        if (Gnt1 !== 1'b1 || Gnt0 !== 1'b0 || Dp_Init0 !== 8'd77)
            $display("FAIL mid_gnt1: got %b%b/%0d want 01/77",
                     Gnt0, Gnt1, Dp_Init0);
        else pass_cnt++;
        sb.push_back('{1'b1, 8'hEE, 8'hDD});
        Req1 = 1'b0;
        wait_done(seen, cyc);
        e = sb.pop_front();
        total_cnt++;
        if (!seen || cyc != 10 || Done_Id !== e.id || Res1 !== e.r1)
            $display("FAIL mid_done: got %0d/%b/%h want 10/%b/%h",
                     cyc, Done_Id, Res1, e.id, e.r1);
        else pass_cnt++;
    endtask

    task automatic test_toggle();
        bit         seen;
        int         bad;
        logic [7:0] cur0;
        logic [7:0] cur1;
        do_reset();
        A0 = 8'd3; B0 = 8'd4; Req0 = 1'b1;
        @(negedge Clk);
        Req0 = 1'b0;
        seen = 0;
        bad = 0;
        cur0 = 8'h00;
        cur1 = 8'h00;
        for (int k = 1; k <= 40; k++) begin
            cur0 = 8'($urandom);
            cur1 = 8'($urandom);
            Dp_Unary0 = cur0;
            Dp_Unary1 = cur1;
            @(negedge Clk);
            if (Done) begin
                seen = 1;
                break;
            end
            if (Res0 !== 8'h00 || Res1 !== 8'h00) bad++;
        end
        total_cnt++;
        if (bad != 0)
            $display("FAIL tog_pre: got %0d early changes want 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (!seen || Res0 !== cur0 || Res1 !== cur1)
            $display("FAIL tog_cap: got %h/%h want %h/%h",
                     Res0, Res1, cur0, cur1);
        else pass_cnt++;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            Dp_Unary0 = 8'($urandom);
            Dp_Unary1 = 8'($urandom);
            @(negedge Clk);
            if (Res0 !== cur0 || Res1 !== cur1) bad++;
        end
        total_cnt++;
        if (bad != 0)
            $display("FAIL tog_post: got %0d changes want 0", bad);
        else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_two();
        test_back_to_back();
        test_late_req();
        test_reset_mid();
        test_toggle();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
